// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - fetch, data-memory and datapath-control bundle for multicycle_control
interface multicycle_control_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 4
);
    logic              start;
    logic              instr_valid;
    logic [OPW-1:0]    opcode;
    logic              equal;
    logic              mem_ack;
    logic              instr_req;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic [ALUOPW-1:0] alu_op;
    logic              mem_req;
    logic              mem_write;
    logic              reg_write;
    logic              pc_en;
    logic              branch_taken;
    logic              illegal;
    logic              busy;
    logic              done;

    modport master (
        input  start, instr_valid, opcode, equal, mem_ack,
        output instr_req, reg_dst, alu_src, mem_to_reg, alu_op, mem_req, mem_write,
               reg_write, pc_en, branch_taken, illegal, busy, done
    );

    modport slave (
        output start, instr_valid, opcode, equal, mem_ack,
        input  instr_req, reg_dst, alu_src, mem_to_reg, alu_op, mem_req, mem_write,
               reg_write, pc_en, branch_taken, illegal, busy, done
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB control FSM; CTRL_PERF_CNT_EN adds instr_cnt/stall_cnt
module multicycle_control #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]          instr_cnt,
    output logic [31:0]          stall_cnt
`endif
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [OPW-1:0] op_q;
    logic           illegal_q;
    logic [3:0]     op4;
    logic           op_bad;
    logic           is_halt, is_nop, is_sw, is_lw, is_bne, is_beq, is_cmp;
    logic           active, start_ok;
    logic           rd_c, as_c, mtr_c;
    logic [3:0]     aop_c;
    logic           instr_req_c, mem_req_c, mem_write_c, reg_write_c, pc_en_c, bt_c;

    assign op4 = op_q[3:0];

    // Any opcode bit above the 16-entry ISA makes the instruction illegal.
    if (OPW > 4) begin : g_wide
        assign op_bad = |op_q[OPW-1:4];
    end else begin : g_narrow
        assign op_bad = 1'b0;
    end

    assign is_halt = !op_bad && (op4 == 4'hF);
    assign is_nop  = op_bad || (op4 == 4'hE);
    assign is_bne  = !op_bad && (op4 == 4'h8);
    assign is_beq  = !op_bad && (op4 == 4'h9);
    assign is_sw   = !op_bad && (op4 == 4'hB);
    assign is_lw   = !op_bad && (op4 == 4'hC);
    assign is_cmp  = !op_bad && (op4 == 4'hD);

    assign active   = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
    assign start_ok = ((state == S_IDLE) || (state == S_DONE)) && bus.start;

    always_comb begin
        rd_c  = 1'b0;
        as_c  = 1'b0;
        mtr_c = 1'b0;
        aop_c = op4;
        if (is_nop) begin
            aop_c = 4'hF;
        end else begin
            case (op4)
                4'h0, 4'h3, 4'h4, 4'h5, 4'h6: rd_c = 1'b1;
                4'h1, 4'h2: begin
                    rd_c = 1'b1;
                    as_c = 1'b1;
                end
                4'h7, 4'hA, 4'hB: as_c = 1'b1;
                4'hC: begin
                    as_c  = 1'b1;
                    mtr_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && bus.instr_valid) op_q <= bus.opcode;
            if (start_ok) illegal_q <= 1'b0;
            else if (state == S_DECODE && op_bad) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        instr_req_c = 1'b0;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        pc_en_c     = 1'b0;
        bt_c        = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nx = S_FETCH;
            S_FETCH: begin
                instr_req_c = 1'b1;
                if (bus.instr_valid) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = is_halt ? S_DONE : S_EXEC;
            S_EXEC: begin
                if (is_nop || is_bne || is_beq || is_cmp) begin
                    pc_en_c  = 1'b1;
                    bt_c     = (is_beq && bus.equal) || (is_bne && !bus.equal);
                    state_nx = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = is_sw;
                if (bus.mem_ack) begin
                    pc_en_c  = is_sw;
                    state_nx = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_en_c     = 1'b1;
                state_nx    = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.instr_req    = instr_req_c;
    assign bus.reg_dst      = active && rd_c;
    assign bus.alu_src      = active && as_c;
    assign bus.mem_to_reg   = active && mtr_c;
    assign bus.alu_op       = active ? ALUOPW'(aop_c) : '0;
    assign bus.mem_req      = mem_req_c;
    assign bus.mem_write    = mem_write_c;
    assign bus.reg_write    = reg_write_c;
    assign bus.pc_en        = pc_en_c;
    assign bus.branch_taken = bt_c;
    assign bus.illegal      = illegal_q;
    assign bus.busy         = (state != S_IDLE) && (state != S_DONE);
    assign bus.done         = (state == S_DONE);

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else if (start_ok) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_en_c || (state == S_DECODE && is_halt)) instr_cnt <= instr_cnt + 32'd1;
            if ((state == S_FETCH && !bus.instr_valid) || (state == S_MEM && !bus.mem_ack))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with a per-instruction latency model
module tb_multicycle_control;
    localparam int OPW = 6;

    logic clk;
    logic reset_n;
    multicycle_control_if #(.OPW(OPW), .ALUOPW(4)) bus ();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_cnt, stall_cnt;
`endif

    multicycle_control #(.OPW(OPW), .ALUOPW(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
`ifdef CTRL_PERF_CNT_EN
        , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       lat;
        int       rw;
        bit       bt;
        int       mreq;
        int       mwr;
        bit       rd, as_, mtr;
        bit [3:0] aop;
        bit       ill;
        bit       halt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   ill_sticky = 0;
    int   n_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outcome of one instruction, straight from the opcode map and cycle budgets.
    function automatic exp_t model(input logic [OPW-1:0] op, input int fw, input int mw,
                                   input bit eq, input bit ill_in);
        exp_t       e;
        logic [3:0] o;
        o = op[3:0];
        e = '{lat: 3 + fw, rw: 0, bt: 0, mreq: 0, mwr: 0, rd: 0, as_: 0, mtr: 0,
              aop: o, ill: ill_in, halt: 0};
        if (op[OPW-1:4] != 0) begin
            e.aop = 4'hF;
            return e;
        end
        case (o)
            4'h0, 4'h3, 4'h4, 4'h5, 4'h6: begin e.rd = 1; e.lat = 4 + fw; e.rw = 1; end
            4'h1, 4'h2: begin e.rd = 1; e.as_ = 1; e.lat = 4 + fw; e.rw = 1; end
            4'h7, 4'hA: begin e.as_ = 1; e.lat = 4 + fw; e.rw = 1; end
            4'h8: e.bt = !eq;
            4'h9: e.bt = eq;
            4'hE: e.aop = 4'hF;
            4'hB: begin e.as_ = 1; e.lat = 4 + fw + mw; e.mreq = mw + 1; e.mwr = mw + 1; end
            4'hC: begin e.as_ = 1; e.mtr = 1; e.lat = 5 + fw + mw; e.mreq = mw + 1; e.rw = 1; end
            4'hF: e.halt = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.instr_req, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op,
                    bus.mem_req, bus.mem_write, bus.reg_write, bus.pc_en, bus.branch_taken,
                    bus.illegal, bus.busy, bus.done});
    endfunction

    task automatic wait_for(input int which, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if ((which == 0 && bus.instr_req) || (which == 1 && bus.mem_req) ||
                (which == 2 && bus.done)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: signal %0d not seen, required within 300 cycles", which);
        end
    endtask

    task automatic run_instr(input logic [OPW-1:0] op, input int fw, input int mw, input bit eq);
        bit ok;
        bit bad;
        bad = (op[OPW-1:4] != 0);
        if (bad) ill_sticky = 1;
        q.push_back(model(op, fw, mw, eq, ill_sticky));
        n_ret++;
        wait_for(0, ok);
        if (!ok) return;
        repeat (fw) @(negedge clk);
        bus.instr_valid = 1;
        bus.opcode      = op;
        @(negedge clk);
        bus.instr_valid = 0;
        bus.opcode      = OPW'($urandom);
        bus.equal       = eq;
        if (!bad && (op[3:0] == 4'hB || op[3:0] == 4'hC)) begin
            wait_for(1, ok);
            if (!ok) return;
            repeat (mw) @(negedge clk);
            bus.mem_ack = 1;
            @(negedge clk);
            bus.mem_ack = 0;
        end
        if (!bad && op[3:0] == 4'hF) begin
            wait_for(2, ok);
            if (!ok) return;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.start = 1;
            @(negedge clk);
            bus.start  = 0;
            ill_sticky = 0;
            n_ret      = 0;
        end
    endtask

    // Monitor: follows each instruction from its first FETCH cycle to its retire cycle.
    bit   in_i;
    int   cyc, rwc, mrc, mwc;
    exp_t me;
    initial begin
        in_i = 0;
        cyc = 0; rwc = 0; mrc = 0; mwc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                in_i = 0;
            end else begin
                chk("branch_taken_without_pc_en", 32'(bus.branch_taken & ~bus.pc_en), 0);
                chk("mem_write_without_mem_req", 32'(bus.mem_write & ~bus.mem_req), 0);
                if (!in_i && bus.instr_req) begin
                    in_i = 1; cyc = 0; rwc = 0; mrc = 0; mwc = 0;
                end
                if (in_i) begin
                    cyc++;
                    rwc += int'(bus.reg_write);
                    mrc += int'(bus.mem_req);
                    mwc += int'(bus.mem_write);
                    if (bus.pc_en || bus.done) begin
                        in_i = 0;
                        if (q.size() == 0) begin
                            chk("unexpected_retire", 1, 0);
                        end else begin
                            me = q.pop_front();
                            chk("latency", cyc, me.lat);
                            if (me.halt) begin
                                chk("halt_done", 32'(bus.done), 1);
                                chk("halt_busy", 32'(bus.busy), 0);
                                chk("halt_pc_en", 32'(bus.pc_en), 0);
                            end else begin
                                chk("reg_write_cycles", rwc, me.rw);
                                chk("branch_taken", 32'(bus.branch_taken), 32'(me.bt));
                                chk("mem_req_cycles", mrc, me.mreq);
                                chk("mem_write_cycles", mwc, me.mwr);
                                chk("reg_dst", 32'(bus.reg_dst), 32'(me.rd));
                                chk("alu_src", 32'(bus.alu_src), 32'(me.as_));
                                chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(me.mtr));
                                chk("alu_op", 32'(bus.alu_op), 32'(me.aop));
                                chk("illegal", 32'(bus.illegal), 32'(me.ill));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset_n         = 0;
        bus.start       = 0;
        bus.instr_valid = 0;
        bus.opcode      = '0;
        bus.equal       = 0;
        bus.mem_ack     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start       = 1'($urandom);
            bus.instr_valid = 1'($urandom);
            bus.opcode      = OPW'($urandom);
            bus.equal       = 1'($urandom);
            bus.mem_ack     = 1'($urandom);
            #2;
            chk("reset_outputs", outs(), 0);
        end
        @(negedge clk);
        bus.start = 0; bus.instr_valid = 0; bus.mem_ack = 0; bus.equal = 0;
        reset_n = 1;
        @(negedge clk);
        bus.start = 1;
        @(posedge clk);
        #2;
        chk("instr_req_after_start", 32'(bus.instr_req), 1);
        bus.start = 0;
        @(negedge clk);

        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b001001, 0, 0, 1);
        run_instr(6'b001001, 0, 0, 0);
        run_instr(6'b001000, 1, 0, 0);
        run_instr(6'b001100, 0, 3, 0);
        run_instr(6'b001011, 0, 0, 0);
        run_instr(6'b001011, 2, 1, 0);
        run_instr(6'b001111, 0, 0, 0);
        run_instr(6'b010000, 0, 0, 0);
        run_instr(6'b001110, 0, 0, 0);
        run_instr(6'b001111, 1, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [OPW-1:0] op;
            op = OPW'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) op[OPW-1:4] = 2'($urandom_range(1, 3));
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        @(negedge clk);
`ifdef CTRL_PERF_CNT_EN
        #2;
        chk("instr_cnt", instr_cnt, n_ret);
`endif

        wait_for(0, ok);
        @(negedge clk);
        bus.instr_valid = 1;
        bus.opcode      = 6'b001011;
        @(negedge clk);
        bus.instr_valid = 0;
        wait_for(1, ok);
        @(negedge clk);
        #1;
        reset_n = 0;
        #1;
        chk("reset_mem_req", 32'(bus.mem_req), 0);
        chk("reset_mem_write", 32'(bus.mem_write), 0);
        chk("reset_pc_en", 32'(bus.pc_en), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        bus.mem_ack = 1;
        @(negedge clk);
        #2;
        chk("reset_hold_outputs", outs(), 0);
`ifdef CTRL_PERF_CNT_EN
        chk("reset_counters", instr_cnt | stall_cnt, 0);
`endif
        bus.mem_ack = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        #2;
        chk("idle_after_reset", outs(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
